alu_scheduler: RTL

//   Shares one 8-bit ALU (op 4'b0000 ADD, 4'b0001 SUB) between NREQ requesters.

---
 rtl/alu_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin scheduler sharing one 8-bit ALU among NREQ requesters
//
// Purpose:
//   Arbitrates NREQ valid/ready request ports onto a single external ALU.
//   One operation is in flight at a time (IDLE -> EXEC -> RESP -> IDLE).
//   The tagged result is returned on one response channel.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester handshake (ready is one-hot or zero)
//   req_op/req_a/req_b     packed per-requester op (4b) and operands (8b)
//   alu_a/alu_b/alu_op     registered drive to the ALU (hold last issued values)
//   alu_out                combinational ALU result
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/rsp_data        requester tag and ALU result
//   busy                   high whenever the FSM is not IDLE
//
// Configuration macro:
//   ALU_SCHED_PRIO_EN      requester 0 gets absolute priority; the others round-robin.

module alu_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  output logic [3:0]        alu_op,
  input  logic [7:0]        alu_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [7:0]        rsp_data,
  output logic              busy
);

`ifdef ALU_SCHED_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      alu_a_q, alu_a_d;
  logic [7:0]      alu_b_q, alu_b_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [3:0]      grant_op;
  logic [7:0]      grant_a;
  logic [7:0]      grant_b;
  logic            grant_upd_rr;
  logic [ID_W-1:0] grant_next_ptr;

  // Winner search. Pass 0 scans indices at or above rr_ptr, pass 1 wraps to the
  // bottom; together they visit rr_ptr, rr_ptr+1, ... mod NREQ using only
  // constant indices. In priority mode requester 0 is taken out of the ring
  // and checked first, and its grant leaves rr_ptr alone.
  always_comb begin
    grant_found    = 1'b0;
    grant_idx      = '0;
    grant_op       = '0;
    grant_a        = '0;
    grant_b        = '0;
    grant_upd_rr   = 1'b0;
    grant_next_ptr = rr_ptr_q;
    if (PRIO_EN && req_valid[0]) begin
      grant_found = 1'b1;
      grant_op    = req_op[3:0];
      grant_a     = req_a[7:0];
      grant_b     = req_b[7:0];
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && !(PRIO_EN && i == 0) &&
            (pass == 1 || i >= int'(rr_ptr_q))) begin
          grant_found    = 1'b1;
          grant_idx      = ID_W'(i);
          grant_op       = req_op[4*i +: 4];
          grant_a        = req_a[8*i +: 8];
          grant_b        = req_b[8*i +: 8];
          grant_upd_rr   = 1'b1;
          grant_next_ptr = (i == NREQ-1) ? '0 : ID_W'(i + 1);
        end
      end
    end
  end

  // Ready is combinational but forced low while reset is asserted.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = reset_n && (state_q == IDLE) && grant_found &&
                     (grant_idx == ID_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          alu_a_d  = grant_a;
          alu_b_d  = grant_b;
          alu_op_d = grant_op;
          rsp_id_d = grant_idx;
          if (grant_upd_rr) rr_ptr_d = grant_next_ptr;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // No grant on the release cycle; IDLE arbitrates on the next one.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);

endmodule
